bcd_event_counter: RTL and testbench

Four-digit BCD event counter between the step-source mux (slow tick or debounced button) and the display controller. It synchronizes the asynchronous step level, detects its rising edges, and counts up or down in packed BCD from 0000 to 9999 with wrap-around. The display stage receives a 16-bit value whose nibbles are always legal decimal digits 0–9, so no binary-to-BCD conversion is needed downstream.

---
 rtl/bcd_event_counter.sv | 82 ++++++++
 tb/tb_bcd_event_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_event_counter.sv
// Four-digit packed-BCD up/down event counter fed by an asynchronous step level.
// Rising edges of inc are synchronized, edge-detected and counted with wrap at 0000/9999.
module bcd_event_counter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inc,
   input  logic        up_down,
   input  logic        hold,
   input  logic        clear,
   output logic [15:0] count,
   output logic        wrap
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic [15:0]            r_count;
   logic                   r_wrap;
   logic                   w_step;
   logic [15:0]            w_next;
   logic                   w_carry;

   // Edge tracking runs independently of hold/clear so held edges are consumed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], inc};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_step = r_sync[SYNC_STAGES-1] & ~r_hist;

   // Per-digit ripple; w_carry left set after the top digit means 9999<->0000.
   always_comb begin
      w_next  = r_count;
      w_carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
         if (w_carry) begin
            if (up_down) begin
               if (r_count[4*d +: 4] == 4'd9) begin
                  w_next[4*d +: 4] = 4'd0;
                  w_carry          = 1'b1;
               end else begin
                  w_next[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                  w_carry          = 1'b0;
               end
            end else begin
               if (r_count[4*d +: 4] == 4'd0) begin
                  w_next[4*d +: 4] = 4'd9;
                  w_carry          = 1'b1;
               end else begin
                  w_next[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
                  w_carry          = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= 16'h0000;
         r_wrap  <= 1'b0;
      end else if (clear) begin
         r_count <= 16'h0000;
         r_wrap  <= 1'b0;
      end else if (w_step && !hold) begin
         r_count <= w_next;
         r_wrap  <= w_carry;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed bench for bcd_event_counter: latency, carries, wraps, hold/clear, pulse widths.
module tb_bcd_event_counter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inc = 1'b0;
   logic        up_down = 1'b1;
   logic        hold = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] count;
   logic        wrap;

   int n_total = 0;
   int n_pass  = 0;

   bcd_event_counter #(.SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .inc(inc), .up_down(up_down),
      .hold(hold), .clear(clear), .count(count), .wrap(wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   // One full step: high 3 cycles then low 3 cycles; count updates before inc drops.
   task automatic do_step(input logic dir);
      @(negedge clk);
      up_down = dir;
      inc = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      inc = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (count !== 16'h0000) $display("FAIL reset_count: got %h want 0000", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else n_pass++;
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_latency();
      up_down = 1'b1;
      inc = 1'b1;
      @(negedge clk);
      n_total++;
      if (count !== 16'h0000) $display("FAIL lat_edge0: got %h want 0000", count); else n_pass++;
      @(negedge clk);
      n_total++;
      if (count !== 16'h0000) $display("FAIL lat_edge1: got %h want 0000", count); else n_pass++;
      @(negedge clk);
      n_total++;
      if (count !== 16'h0001) $display("FAIL lat_edge2: got %h want 0001", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b0) $display("FAIL lat_wrap: got %b want 0", wrap); else n_pass++;
      inc = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_carry();
      logic ok;
      do_clear();
      ok = 1'b1;
      for (int i = 0; i < 199; i++) begin
         do_step(1'b1);
         for (int d = 0; d < 4; d++) if (count[4*d +: 4] > 4'd9) ok = 1'b0;
      end
      n_total++;
      if (count !== 16'h0199) $display("FAIL carry_0199: got %h want 0199", count); else n_pass++;
      do_step(1'b1);
      n_total++;
      if (count !== 16'h0200) $display("FAIL carry_0200: got %h want 0200", count); else n_pass++;
      for (int i = 0; i < 799; i++) begin
         do_step(1'b1);
         for (int d = 0; d < 4; d++) if (count[4*d +: 4] > 4'd9) ok = 1'b0;
      end
      n_total++;
      if (count !== 16'h0999) $display("FAIL carry_0999: got %h want 0999", count); else n_pass++;
      do_step(1'b1);
      n_total++;
      if (count !== 16'h1000) $display("FAIL carry_1000: got %h want 1000", count); else n_pass++;
      n_total++;
      if (ok !== 1'b1) $display("FAIL carry_nibbles: got illegal digit %b want 1", ok); else n_pass++;
      do_step(1'b0);
      n_total++;
      if (count !== 16'h0999) $display("FAIL borrow_0999: got %h want 0999", count); else n_pass++;
   endtask

   task automatic test_down_wrap();
      do_clear();
      @(negedge clk);
      up_down = 1'b0;
      inc = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (count !== 16'h9999) $display("FAIL dwrap_count: got %h want 9999", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b1) $display("FAIL dwrap_pulse: got %b want 1", wrap); else n_pass++;
      @(negedge clk);
      n_total++;
      if (wrap !== 1'b0) $display("FAIL dwrap_one_cycle: got %b want 0", wrap); else n_pass++;
      inc = 1'b0;
      repeat (3) @(negedge clk);
      inc = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (count !== 16'h9998) $display("FAIL dwrap_9998: got %h want 9998", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b0) $display("FAIL dwrap_9998_wrap: got %b want 0", wrap); else n_pass++;
      inc = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_up_wrap();
      do_step(1'b1);
      n_total++;
      if (count !== 16'h9999) $display("FAIL uwrap_9999: got %h want 9999", count); else n_pass++;
      @(negedge clk);
      up_down = 1'b1;
      inc = 1'b1;
      repeat (2) @(negedge clk);
      n_total++;
      if (wrap !== 1'b0) $display("FAIL uwrap_early: got %b want 0", wrap); else n_pass++;
      @(negedge clk);
      n_total++;
      if (count !== 16'h0000) $display("FAIL uwrap_count: got %h want 0000", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b1) $display("FAIL uwrap_pulse: got %b want 1", wrap); else n_pass++;
      @(negedge clk);
      n_total++;
      if (wrap !== 1'b0) $display("FAIL uwrap_one_cycle: got %b want 0", wrap); else n_pass++;
      inc = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_hold_clear();
      do_clear();
      for (int i = 0; i < 42; i++) do_step(1'b1);
      n_total++;
      if (count !== 16'h0042) $display("FAIL hold_pre: got %h want 0042", count); else n_pass++;
      @(negedge clk);
      hold = 1'b1;
      up_down = 1'b1;
      inc = 1'b1;
      repeat (4) @(negedge clk);
      n_total++;
      if (count !== 16'h0042) $display("FAIL hold_during: got %h want 0042", count); else n_pass++;
      hold = 1'b0;
      repeat (3) @(negedge clk);
      inc = 1'b0;
      repeat (4) @(negedge clk);
      n_total++;
      if (count !== 16'h0042) $display("FAIL hold_no_replay: got %h want 0042", count); else n_pass++;
      // Step reaches the counter on the third edge; clear coincides with it.
      inc = 1'b1;
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_total++;
      if (count !== 16'h0000) $display("FAIL clear_count: got %h want 0000", count); else n_pass++;
      n_total++;
      if (wrap !== 1'b0) $display("FAIL clear_wrap: got %b want 0", wrap); else n_pass++;
      repeat (3) @(negedge clk);
      inc = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (count !== 16'h0000) $display("FAIL clear_discard: got %h want 0000", count); else n_pass++;
   endtask

   task automatic test_long_and_glitch();
      do_clear();
      @(negedge clk);
      up_down = 1'b1;
      inc = 1'b1;
      repeat (50) @(negedge clk);
      n_total++;
      if (count !== 16'h0001) $display("FAIL long_level: got %h want 0001", count); else n_pass++;
      inc = 1'b0;
      repeat (4) @(negedge clk);
      inc = 1'b1;
      @(negedge clk);
      inc = 1'b0;
      repeat (6) @(negedge clk);
      n_total++;
      if (count !== 16'h0001 && count !== 16'h0002)
         $display("FAIL glitch: got %h want 0001 or 0002", count);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_step(1'b1);
      n_total++;
      if (count === 16'h0000) $display("FAIL areset_pre: got %h want nonzero", count); else n_pass++;
      #2;
      resetn = 1'b0;
      #1;
      n_total++;
      if (count !== 16'h0000) $display("FAIL areset_count: got %h want 0000", count); else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_carry();
      test_down_wrap();
      test_up_wrap();
      test_hold_clear();
      test_long_and_glitch();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
